// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the HH:MM:SS BCD counter chain: freezes the counters,
// steps hours then minutes from two buttons, and writes the preset back with a load pulse.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned REPEAT_DELAY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_ten_hour,
    input  logic [3:0] cur_one_hour,
    input  logic [3:0] cur_ten_min,
    input  logic [3:0] cur_one_min,
    output logic       stop,
    output logic       load,
    output logic [3:0] set_ten_hour,
    output logic [3:0] set_one_hour,
    output logic [3:0] set_ten_min,
    output logic [3:0] set_one_min,
    output logic       blank_hour,
    output logic       blank_min,
    output logic [1:0] mode
);

    localparam int unsigned IdleW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_TICKS - 1);
    localparam int unsigned HoldW = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(REPEAT_DELAY);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StLoad    = 2'b11
    } state_e;

    state_e state_q, state_d;

    // [0],[1]: synchronizer flops; [2]: previous synchronized level for edge detect.
    logic [2:0] mode_sync_q, inc_sync_q;
    logic       mode_press, inc_press, inc_level;

    logic [3:0] ten_hour_q, ten_hour_d, one_hour_q, one_hour_d;
    logic [3:0] ten_min_q, ten_min_d, one_min_q, one_min_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic       blink_q, blink_d;
    logic       bump;
    logic       stop_q, load_q, blank_hour_q, blank_min_q;

    assign mode_press = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_press  = inc_sync_q[1] & ~inc_sync_q[2];
    assign inc_level  = inc_sync_q[1];

    always_comb begin
        state_d    = state_q;
        ten_hour_d = ten_hour_q;
        one_hour_d = one_hour_q;
        ten_min_d  = ten_min_q;
        one_min_d  = one_min_q;
        hold_d     = hold_q;
        idle_d     = idle_q;
        blink_d    = blink_q;
        bump       = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mode_press) begin
                    state_d    = StSetHour;
                    ten_hour_d = cur_ten_hour;
                    one_hour_d = cur_one_hour;
                    ten_min_d  = cur_ten_min;
                    one_min_d  = cur_one_min;
                end
            end
            StSetHour, StSetMin: begin
                // A mode press takes priority and swallows any inc in the same cycle.
                if (mode_press) begin
                    state_d = (state_q == StSetHour) ? StSetMin : StLoad;
                end else begin
                    bump = inc_press | (tick & inc_level & (hold_q == HoldMax));
                    if (bump) begin
                        idle_d = '0;
                    end else if (tick) begin
                        if (idle_q == IdleLast) begin
                            state_d = StRun;
                        end else begin
                            idle_d = idle_q + IdleW'(1);
                        end
                    end
                end
                if (tick) begin
                    blink_d = ~blink_q;
                end
                if (!inc_level) begin
                    hold_d = '0;
                end else if (tick && (hold_q != HoldMax)) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StLoad: begin
                state_d = StRun;
            end
        endcase

        if (bump) begin
            if (state_q == StSetHour) begin
                if ((ten_hour_q == 4'd2) && (one_hour_q == 4'd3)) begin
                    ten_hour_d = 4'd0;
                    one_hour_d = 4'd0;
                end else if (one_hour_q == 4'd9) begin
                    ten_hour_d = ten_hour_q + 4'd1;
                    one_hour_d = 4'd0;
                end else begin
                    one_hour_d = one_hour_q + 4'd1;
                end
            end else begin
                if (one_min_q == 4'd9) begin
                    one_min_d = 4'd0;
                    ten_min_d = (ten_min_q == 4'd5) ? 4'd0 : ten_min_q + 4'd1;
                end else begin
                    one_min_d = one_min_q + 4'd1;
                end
            end
        end

        if (state_d != state_q) begin
            hold_d  = '0;
            idle_d  = '0;
            blink_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            mode_sync_q  <= '0;
            inc_sync_q   <= '0;
            ten_hour_q   <= '0;
            one_hour_q   <= '0;
            ten_min_q    <= '0;
            one_min_q    <= '0;
            hold_q       <= '0;
            idle_q       <= '0;
            blink_q      <= 1'b0;
            stop_q       <= 1'b0;
            load_q       <= 1'b0;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_sync_q  <= {mode_sync_q[1:0], btn_mode};
            inc_sync_q   <= {inc_sync_q[1:0], btn_inc};
            ten_hour_q   <= ten_hour_d;
            one_hour_q   <= one_hour_d;
            ten_min_q    <= ten_min_d;
            one_min_q    <= one_min_d;
            hold_q       <= hold_d;
            idle_q       <= idle_d;
            blink_q      <= blink_d;
            stop_q       <= (state_d != StRun);
            load_q       <= (state_d == StLoad);
            blank_hour_q <= (state_d == StSetHour) & blink_d;
            blank_min_q  <= (state_d == StSetMin) & blink_d;
        end
    end

    assign stop         = stop_q;
    assign load         = load_q;
    assign blank_hour   = blank_hour_q;
    assign blank_min    = blank_min_q;
    assign mode         = state_q;
    assign set_ten_hour = ten_hour_q;
    assign set_one_hour = one_hour_q;
    assign set_ten_min  = ten_min_q;
    assign set_one_min  = one_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus random stimulus
// checked against an integer hour/minute reference model.
module tb_clock_set_ctrl;

    localparam int unsigned TO = 10;
    localparam int unsigned RD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_ten_hour = '0, cur_one_hour = '0, cur_ten_min = '0, cur_one_min = '0;
    logic       stop, load, blank_hour, blank_min;
    logic [3:0] set_ten_hour, set_one_hour, set_ten_min, set_one_min;
    logic [1:0] mode;

    int total = 0;
    int bad = 0;
    int cur_hour = 0;
    int cur_min = 0;

    // Reference model: state 0=run 1=set hour 2=set minute 3=load; time as plain integers.
    int m_state = 0, m_hour = 0, m_min = 0, m_held = 0, m_idle = 0;
    bit m_blink = 1'b0;
    bit hm[3];
    bit hi[3];

    clock_set_ctrl #(.TIMEOUT_TICKS(TO), .REPEAT_DELAY(RD)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_ten_hour(cur_ten_hour), .cur_one_hour(cur_one_hour),
        .cur_ten_min(cur_ten_min), .cur_one_min(cur_one_min),
        .stop(stop), .load(load),
        .set_ten_hour(set_ten_hour), .set_one_hour(set_one_hour),
        .set_ten_min(set_ten_min), .set_one_min(set_one_min),
        .blank_hour(blank_hour), .blank_min(blank_min), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic model_update(input bit m, input bit i, input bit t, input bit r);
        bit pm, pi, lv, bump;
        int nxt;
        if (r) begin
            m_state = 0; m_hour = 0; m_min = 0; m_held = 0; m_idle = 0; m_blink = 1'b0;
            for (int k = 0; k < 3; k++) begin
                hm[k] = 1'b0;
                hi[k] = 1'b0;
            end
        end else begin
            // A raw press becomes visible to the controller two samples later.
            pm = hm[1] && !hm[2];
            pi = hi[1] && !hi[2];
            lv = hi[1];
            bump = 1'b0;
            nxt = m_state;
            case (m_state)
                0: if (pm) begin
                    nxt = 1; m_hour = cur_hour; m_min = cur_min;
                end
                1, 2: begin
                    if (pm) nxt = (m_state == 1) ? 2 : 3;
                    else begin
                        bump = pi || (t && lv && (m_held >= int'(RD)));
                        if (bump) begin
                            if (m_state == 1) m_hour = (m_hour + 1) % 24;
                            else m_min = (m_min + 1) % 60;
                            m_idle = 0;
                        end else if (t) begin
                            m_idle++;
                            if (m_idle >= int'(TO)) nxt = 0;
                        end
                    end
                    if (t) m_blink = !m_blink;
                    if (!lv) m_held = 0;
                    else if (t) m_held++;
                end
                default: nxt = 0;
            endcase
            if (nxt != m_state) begin
                m_held = 0; m_idle = 0; m_blink = 1'b0;
            end
            m_state = nxt;
            hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = m;
            hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = i;
        end
    endtask

    function automatic logic [21:0] model_out();
        logic [1:0] st;
        st = 2'(m_state);
        return {st, (m_state != 0), (m_state == 3), (m_state == 1) && m_blink,
                (m_state == 2) && m_blink, 4'(m_hour / 10), 4'(m_hour % 10),
                4'(m_min / 10), 4'(m_min % 10)};
    endfunction

    task automatic step(input bit m, input bit i, input bit t, input bit r);
        btn_mode = m; btn_inc = i; tick = t; rst = r;
        cur_ten_hour = 4'(cur_hour / 10);
        cur_one_hour = 4'(cur_hour % 10);
        cur_ten_min  = 4'(cur_min / 10);
        cur_one_min  = 4'(cur_min % 10);
        @(posedge clk);
        model_update(m, i, t, r);
        #1;
    endtask

    task automatic press(input bit m, input bit i);
        step(m, i, 0, 0);
        step(m, i, 0, 0);
        repeat (3) step(0, 0, 0, 0);
    endtask

    task automatic go_run();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cur_hour = 12; cur_min = 34;
        repeat (3) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        total++;
        if (mode !== 2'b00) begin
            bad++; $display("FAIL reset_mode got=%b want=00", mode);
        end
        total++;
        if ({stop, load, blank_hour, blank_min} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {stop, load, blank_hour, blank_min});
        end
        total++;
        if ({set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 16'h0000) begin
            bad++; $display("FAIL reset_set got=%h want=0000",
                            {set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
    endtask

    task automatic test_enter();
        int seen = 0;
        bit load_seen = 1'b0;
        go_run();
        cur_hour = 12; cur_min = 34;
        for (int n = 1; n <= 8; n++) begin
            step(n <= 2, 0, 0, 0);
            if (load === 1'b1) load_seen = 1'b1;
            if (seen == 0 && mode === 2'b01) seen = n;
        end
        total++;
        if (seen == 0 || seen > 4) begin
            bad++; $display("FAIL enter_latency got=%0d cycles want=1..4", seen);
        end
        total++;
        if (stop !== 1'b1) begin
            bad++; $display("FAIL enter_stop got=%b want=1", stop);
        end
        total++;
        if ({set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 16'h1234) begin
            bad++; $display("FAIL enter_capture got=%h want=1234",
                            {set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
        total++;
        if (load_seen) begin
            bad++; $display("FAIL enter_load got=1 want=0");
        end
    endtask

    task automatic test_hour_wrap();
        go_run();
        cur_hour = 23; cur_min = 15;
        press(1, 0);
        press(0, 1);
        total++;
        if ({mode, set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 18'h1_0015) begin
            bad++; $display("FAIL hour_wrap_23 got=%h want=10015",
                            {mode, set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
        go_run();
        cur_hour = 9; cur_min = 15;
        press(1, 0);
        press(0, 1);
        total++;
        if ({set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 16'h1015) begin
            bad++; $display("FAIL hour_carry_09 got=%h want=1015",
                            {set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
    endtask

    task automatic test_min_wrap_load();
        int load_cnt = 0;
        bit load_bad_mode = 1'b0;
        go_run();
        cur_hour = 5; cur_min = 59;
        press(1, 0);
        press(1, 0);
        total++;
        if (mode !== 2'b10) begin
            bad++; $display("FAIL set_min_entry got=%b want=10", mode);
        end
        press(0, 1);
        total++;
        if ({set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 16'h0500) begin
            bad++; $display("FAIL min_wrap got=%h want=0500",
                            {set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
        for (int n = 1; n <= 8; n++) begin
            step(n <= 2, 0, 0, 0);
            if (load === 1'b1) begin
                load_cnt++;
                if (mode !== 2'b11 || stop !== 1'b1) load_bad_mode = 1'b1;
            end
        end
        total++;
        if (load_cnt != 1) begin
            bad++; $display("FAIL load_width got=%0d cycles want=1", load_cnt);
        end
        total++;
        if (load_bad_mode) begin
            bad++; $display("FAIL load_state got=not_11 want=11_with_stop");
        end
        total++;
        if ({mode, stop} !== 3'b000) begin
            bad++; $display("FAIL after_load got=%b want=000", {mode, stop});
        end
        total++;
        if ({set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 16'h0500) begin
            bad++; $display("FAIL load_hold got=%h want=0500",
                            {set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
    endtask

    task automatic test_autorepeat();
        go_run();
        cur_hour = 14; cur_min = 0;
        press(1, 0);
        press(1, 0);
        repeat (4) step(0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 1, 0);
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        repeat (4) step(0, 0, 0, 0);
        total++;
        if ({set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 16'h1405) begin
            bad++; $display("FAIL autorepeat got=%h want=1405",
                            {set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
        repeat (3) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
        end
        total++;
        if ({mode, set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 18'h2_1405) begin
            bad++; $display("FAIL repeat_release got=%h want=21405",
                            {mode, set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
    endtask

    task automatic test_timeout();
        bit load_seen = 1'b0;
        go_run();
        cur_hour = 8; cur_min = 30;
        press(1, 0);
        total++;
        if ({mode, blank_hour} !== 3'b010) begin
            bad++; $display("FAIL timeout_entry got=%b want=010", {mode, blank_hour});
        end
        for (int k = 1; k <= int'(TO); k++) begin
            step(0, 0, 1, 0);
            if (load === 1'b1) load_seen = 1'b1;
            if (k < int'(TO)) begin
                total++;
                if ({mode, blank_hour} !== {2'b01, 1'(k % 2)}) begin
                    bad++; $display("FAIL blink_tick%0d got=%b want=01%0d", k, {mode, blank_hour},
                                    k % 2);
                end
            end
            repeat (2) begin
                step(0, 0, 0, 0);
                if (load === 1'b1) load_seen = 1'b1;
            end
        end
        total++;
        if ({mode, stop, blank_hour} !== 4'b0000) begin
            bad++; $display("FAIL timeout_exit got=%b want=0000", {mode, stop, blank_hour});
        end
        total++;
        if (load_seen) begin
            bad++; $display("FAIL timeout_load got=1 want=0");
        end
    endtask

    task automatic test_simultaneous();
        go_run();
        cur_hour = 7; cur_min = 20;
        press(1, 0);
        press(1, 1);
        total++;
        if ({mode, set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 18'h2_0720) begin
            bad++; $display("FAIL mode_wins got=%h want=20720",
                            {mode, set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
        step(0, 0, 0, 1);
        total++;
        if ({mode, stop, load, set_ten_hour, set_one_hour, set_ten_min, set_one_min} !== 20'h0) begin
            bad++; $display("FAIL rst_mid_edit got=%h want=00000",
                            {mode, stop, load, set_ten_hour, set_one_hour, set_ten_min, set_one_min});
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit mraw = 1'b0, iraw = 1'b0, t, r;
        int mrate = 20, irate = 10;
        logic [21:0] exp_v, act_v;
        go_run();
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                mrate = $urandom_range(3, 60);
                irate = $urandom_range(3, 30);
            end
            if ($urandom_range(0, mrate) == 0) mraw = !mraw;
            if ($urandom_range(0, irate) == 0) iraw = !iraw;
            if ($urandom_range(0, 60) == 0) begin
                cur_hour = $urandom_range(0, 23);
                cur_min  = $urandom_range(0, 59);
            end
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 999) == 0);
            step(mraw, iraw, t, r);
            exp_v = model_out();
            act_v = {mode, stop, load, blank_hour, blank_min,
                     set_ten_hour, set_one_hour, set_ten_min, set_one_min};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL random_cycle%0d got=%h want=%h (mode,stop,load,bh,bm,hhmm)",
                         c, act_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_hour_wrap();
        test_min_wrap_load();
        test_autorepeat();
        test_timeout();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
